// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core (package)
//  Purpose  : Types and constants shared by the fetch stage, its skid buffer
//             and the decode-side stream interface.
//  Contents : RESET_ADDR_DEFAULT  default first PC after reset
//             fetch_t             {pc, ir} pair carried to decode
//             word_align()        clears the two byte-offset bits of a PC
//  Revision : 1.0  initial release
// ============================================================================
package core;

   localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

   // pc occupies the upper half so the packed value reads {pc, ir}.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } fetch_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis (interface)
//  Purpose  : Valid/ready stream carrying one fetch_t per handshake.
//  Signals  : tdata  [63:0] {pc, ir}
//             tvalid        producer has data
//             tready        consumer accepts data
//  Modports : master (producer), slave (consumer)
//  Revision : 1.0  initial release
// ============================================================================
interface axis;

   core::fetch_t tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module   : skid
//  Purpose  : One-entry skid buffer between the instruction memory return
//             path (which cannot stall) and the decode stream.
//  Ports    : clk, reset      clock, async active-high reset
//             i_flush         drop the held entry at the next edge
//             i_valid/i_data  returning instruction, valid this cycle only
//             i_ready         decode ready
//             o_valid/o_data  decode stream output
//             o_free_next     entry will be empty next cycle, so an issue
//                             made now can always be absorbed
//  Revision : 1.0  initial release
// ============================================================================
module skid
   import core::*;
(
   input  wire          clk,
   input  wire          reset,
   input  wire          i_flush,
   input  wire          i_valid,
   input  wire fetch_t  i_data,
   input  wire          i_ready,
   output logic         o_valid,
   output fetch_t       o_data,
   output logic         o_free_next
);

   logic   r_valid;
   fetch_t r_data;
   logic   w_load;
   logic   w_next_valid;

   // Held entry is always older than the returning word, so it goes first.
   assign o_valid = r_valid | i_valid;
   assign o_data  = r_valid ? r_data : i_data;

   // Returning word must be parked if it is not the one leaving this cycle.
   assign w_load       = i_valid & (r_valid | ~i_ready);
   assign w_next_valid = (r_valid & ~i_ready) | w_load;
   assign o_free_next  = ~w_next_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= w_next_valid & ~i_flush;
         if (w_load) begin
            r_data <= i_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Purpose  : Instruction fetch stage. Owns the PC, issues word reads to the
//             instruction memory and streams {pc, ir} to decode, honouring
//             hazard bubbles, decode backpressure and execute redirects.
//  Ports    : clk, reset            clock, async active-high reset
//             bubble                hazard stall, blocks new fetches
//             redirect_valid/target jump or taken branch from execute
//             imem_en/addr          memory read strobe and byte address
//             imem_data             read data, one cycle after imem_en
//             decode                axis master, tdata = {pc, ir}
//  Revision : 1.0  initial release
// ============================================================================
module fetch
   import core::*;
#(
   parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
)(
   input  wire         clk,
   input  wire         reset,
   input  wire         bubble,
   input  wire         redirect_valid,
   input  wire  [31:0] redirect_target,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  wire  [31:0] imem_data,
   axis.master         decode
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_inflight_valid;
   logic [31:0] r_inflight_pc;

   fetch_t      w_ret;
   logic        w_slot_free;
   logic        w_issue;

   // A redirect this cycle or a flush cycle counts as a pending redirect.
   // Reset gates the strobe directly so it drops with the async reset.
   assign w_issue = ~reset & ~bubble & ~redirect_valid
                  & (r_state != ST_FLUSH) & w_slot_free;

   assign imem_en   = w_issue;
   assign imem_addr = r_pc;

   // The in-flight tag pairs the returning word with its fetch address.
   assign w_ret.pc = r_inflight_pc;
   assign w_ret.ir = imem_data;

   // A redirect clears both the in-flight tag and the skid entry, so the
   // flush cycle presents nothing to decode and stale data is ignored.
   skid u_skid (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (redirect_valid),
      .i_valid     (r_inflight_valid),
      .i_data      (w_ret),
      .i_ready     (decode.tready),
      .o_valid     (decode.tvalid),
      .o_data      (decode.tdata),
      .o_free_next (w_slot_free)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state          <= ST_RUN;
         r_pc             <= word_align(RESET_ADDR);
         r_inflight_valid <= 1'b0;
         r_inflight_pc    <= '0;
      end else begin
         r_inflight_valid <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_pc;
         end

         if (redirect_valid) begin
            r_pc <= word_align(redirect_target);
         end else if (w_issue) begin
            r_pc <= r_pc + 32'd4;
         end

         // Redirect dominates from any state; otherwise the state tracks
         // whether this cycle was blocked by a bubble or a full output path.
         case (r_state)
            ST_RUN, ST_STALL, ST_FLUSH: begin
               if (redirect_valid) begin
                  r_state <= ST_FLUSH;
               end else if (bubble || !w_slot_free) begin
                  r_state <= ST_STALL;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fetch
//  Purpose  : Self-checking bench for fetch. Inputs change 1ns after the
//             rising edge, outputs are sampled on the falling edge. The
//             memory returns a deterministic word per address, so every
//             delivered ir can be tied back to its pc.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch;
   import core::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        bubble;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] seed;

   int n_pass  = 0;
   int n_total = 0;

   logic        s_en, s_valid, s_ready;
   logic [31:0] s_addr, s_pc, s_ir;

   axis decode_if ();

   fetch #(.RESET_ADDR(32'h0000_0000)) dut (
      .clk             (clk),
      .reset           (reset),
      .bubble          (bubble),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_en         (imem_en),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .decode          (decode_if)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ir_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ seed;
   endfunction

   // Word is valid only the cycle after the strobe; otherwise noise.
   always @(posedge clk) imem_data <= imem_en ? ir_of(imem_addr) : $urandom();

   task automatic sample();
      @(negedge clk);
      s_en    = imem_en;
      s_addr  = imem_addr;
      s_valid = decode_if.tvalid;
      s_ready = decode_if.tready;
      s_pc    = decode_if.tdata.pc;
      s_ir    = decode_if.tdata.ir;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; bubble = 1'b0; redirect_valid = 1'b0;
      redirect_target = '0; decode_if.tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; bubble = 1'b0; redirect_valid = 1'b0;
      redirect_target = '0; decode_if.tready = 1'b1;
      sample();
      n_total++; if (s_en !== 1'b0) $display("FAIL reset_en: imem_en=%b required 0", s_en); else n_pass++;
      n_total++; if (s_valid !== 1'b0) $display("FAIL reset_tvalid: tvalid=%b required 0", s_valid); else n_pass++;
      @(posedge clk); #1 reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sample();
         n_total++;
         if (s_en !== 1'b1 || s_addr !== 32'(4 * k))
            $display("FAIL reset_issue k=%0d: en=%b addr=%h required 1 %h", k, s_en, s_addr, 32'(4 * k));
         else n_pass++;
         n_total++;
         if (k == 0) begin
            if (s_valid !== 1'b0) $display("FAIL reset_first_valid: tvalid=%b required 0", s_valid); else n_pass++;
         end else begin
            if (s_valid !== 1'b1 || s_pc !== 32'(4 * (k - 1)) || s_ir !== ir_of(32'(4 * (k - 1))))
               $display("FAIL reset_stream k=%0d: valid=%b pc=%h ir=%h required 1 %h %h",
                        k, s_valid, s_pc, s_ir, 32'(4 * (k - 1)), ir_of(32'(4 * (k - 1))));
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_bubble();
      logic [31:0] q[$];
      do_reset();
      for (int k = 0; k < 12; k++) begin
         bubble = (k >= 4 && k <= 6);
         sample();
         if (bubble) begin
            n_total++;
            if (s_en !== 1'b0 || s_addr !== 32'h10)
               $display("FAIL bubble_hold k=%0d: en=%b addr=%h required 0 00000010", k, s_en, s_addr);
            else n_pass++;
         end
         if (k == 7) begin
            n_total++;
            if (s_en !== 1'b1 || s_addr !== 32'h10)
               $display("FAIL bubble_resume: en=%b addr=%h required 1 00000010", s_en, s_addr);
            else n_pass++;
         end
         if (k == 8) begin
            n_total++;
            if (s_valid !== 1'b1 || s_pc !== 32'h10)
               $display("FAIL bubble_deliver: valid=%b pc=%h required 1 00000010", s_valid, s_pc);
            else n_pass++;
         end
         if (s_valid && s_ready) q.push_back(s_pc);
         advance();
      end
      bubble = 1'b0;
      n_total++; if (q.size() != 8) $display("FAIL bubble_count: got %0d required 8", q.size()); else n_pass++;
      foreach (q[i]) begin
         n_total++;
         if (q[i] !== 32'(4 * i)) $display("FAIL bubble_seq i=%0d: pc=%h required %h", i, q[i], 32'(4 * i)); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] q[$];
      do_reset();
      for (int k = 0; k < 16; k++) begin
         decode_if.tready = !(k >= 5 && k <= 8);
         sample();
         if (!s_ready) begin
            n_total++;
            if (s_valid !== 1'b1 || s_pc !== 32'h10 || s_ir !== ir_of(32'h10))
               $display("FAIL bp_hold k=%0d: valid=%b pc=%h ir=%h required 1 00000010 %h",
                        k, s_valid, s_pc, s_ir, ir_of(32'h10));
            else n_pass++;
         end
         if (s_valid && s_ready) q.push_back(s_pc);
         advance();
      end
      n_total++; if (q.size() != 11) $display("FAIL bp_count: got %0d required 11", q.size()); else n_pass++;
      foreach (q[i]) begin
         n_total++;
         if (q[i] !== 32'(4 * i)) $display("FAIL bp_seq i=%0d: pc=%h required %h", i, q[i], 32'(4 * i)); else n_pass++;
      end
   endtask

   task automatic test_redirect();
      logic [31:0] q[$];
      logic [31:0] exp_pc;
      do_reset();
      redirect_target = 32'h200;
      for (int k = 0; k < 15; k++) begin
         redirect_valid = (k == 8);
         sample();
         if (k == 8) begin
            n_total++;
            if (s_en !== 1'b0) $display("FAIL redir_no_issue: en=%b required 0", s_en); else n_pass++;
            n_total++;
            if (s_valid !== 1'b1 || s_pc !== 32'h1C)
               $display("FAIL redir_handshake: valid=%b pc=%h required 1 0000001c", s_valid, s_pc);
            else n_pass++;
         end
         if (k == 9) begin
            n_total++;
            if (s_valid !== 1'b0 || s_en !== 1'b0)
               $display("FAIL redir_flush: valid=%b en=%b required 0 0", s_valid, s_en);
            else n_pass++;
         end
         if (k == 10) begin
            n_total++;
            if (s_en !== 1'b1 || s_addr !== 32'h200)
               $display("FAIL redir_target: en=%b addr=%h required 1 00000200", s_en, s_addr);
            else n_pass++;
         end
         if (s_valid && s_ready) q.push_back(s_pc);
         advance();
      end
      redirect_valid = 1'b0;
      n_total++; if (q.size() != 12) $display("FAIL redir_count: got %0d required 12", q.size()); else n_pass++;
      foreach (q[i]) begin
         exp_pc = (i < 8) ? 32'(4 * i) : 32'h200 + 32'(4 * (i - 8));
         n_total++;
         if (q[i] !== exp_pc) $display("FAIL redir_seq i=%0d: pc=%h required %h", i, q[i], exp_pc); else n_pass++;
      end
   endtask

   task automatic test_redirect_bubble();
      do_reset();
      redirect_target = 32'h103;
      for (int k = 0; k < 9; k++) begin
         redirect_valid = (k == 3);
         bubble = (k >= 3 && k <= 5);
         sample();
         if (k >= 3 && k <= 5) begin
            n_total++;
            if (s_en !== 1'b0) $display("FAIL rb_no_issue k=%0d: en=%b required 0", k, s_en); else n_pass++;
         end
         if (k >= 4 && k <= 6) begin
            n_total++;
            if (s_valid !== 1'b0) $display("FAIL rb_no_valid k=%0d: valid=%b required 0", k, s_valid); else n_pass++;
         end
         if (k == 6) begin
            n_total++;
            if (s_en !== 1'b1 || s_addr !== 32'h100)
               $display("FAIL rb_first: en=%b addr=%h required 1 00000100", s_en, s_addr);
            else n_pass++;
         end
         if (k == 7) begin
            n_total++;
            if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_ir !== ir_of(32'h100))
               $display("FAIL rb_deliver: valid=%b pc=%h required 1 00000100", s_valid, s_pc);
            else n_pass++;
         end
         advance();
      end
      redirect_valid = 1'b0; bubble = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      do_reset();
      redirect_target = 32'hFFFF_FFF4;
      for (int k = 0; k < 10; k++) begin
         redirect_valid = (k == 2);
         sample();
         if (k == 7) begin
            n_total++;
            if (s_en !== 1'b1 || s_addr !== 32'h0)
               $display("FAIL wrap_addr: en=%b addr=%h required 1 00000000", s_en, s_addr);
            else n_pass++;
         end
         if (k >= 5) begin
            exp_pc = 32'hFFFF_FFF4 + 32'(4 * (k - 5));
            n_total++;
            if (s_valid !== 1'b1 || s_pc !== exp_pc)
               $display("FAIL wrap_seq k=%0d: valid=%b pc=%h required 1 %h", k, s_valid, s_pc, exp_pc);
            else n_pass++;
         end
         advance();
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         decode_if.tready = (k < 3);
         sample();
         if (k < 5) advance();
      end
      n_total++; if (s_valid !== 1'b1) $display("FAIL areset_pre: valid=%b required 1", s_valid); else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (decode_if.tvalid !== 1'b0 || imem_en !== 1'b0)
         $display("FAIL areset_drop: valid=%b en=%b required 0 0", decode_if.tvalid, imem_en);
      else n_pass++;
      @(posedge clk); #1 reset = 1'b0; decode_if.tready = 1'b1;
      sample();
      n_total++;
      if (s_en !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0)
         $display("FAIL areset_restart: en=%b addr=%h valid=%b required 1 00000000 0", s_en, s_addr, s_valid);
      else n_pass++;
      advance();
   endtask

   task automatic test_random();
      logic [31:0] next_pc, held_pc, held_ir;
      logic        prev_hold, prev_redirect;
      int          delivered;
      do_reset();
      next_pc = 32'h0; prev_hold = 1'b0; prev_redirect = 1'b0; delivered = 0;
      held_pc = '0; held_ir = '0;
      for (int c = 0; c < 3000; c++) begin
         bubble           = ($urandom_range(3) == 0);
         decode_if.tready = ($urandom_range(2) != 0);
         redirect_valid   = ($urandom_range(39) == 0);
         redirect_target  = $urandom();
         sample();
         if (bubble || redirect_valid) begin
            n_total++;
            if (s_en !== 1'b0) $display("FAIL rnd_blocked c=%0d: en=%b required 0", c, s_en); else n_pass++;
         end
         if (prev_redirect) begin
            n_total++;
            if (s_valid !== 1'b0) $display("FAIL rnd_flush c=%0d: valid=%b required 0", c, s_valid); else n_pass++;
         end
         if (prev_hold) begin
            n_total++;
            if (s_valid !== 1'b1 || s_pc !== held_pc || s_ir !== held_ir)
               $display("FAIL rnd_stable c=%0d: valid=%b pc=%h ir=%h required 1 %h %h",
                        c, s_valid, s_pc, s_ir, held_pc, held_ir);
            else n_pass++;
         end
         if (s_valid && s_ready) begin
            n_total++;
            if (s_pc !== next_pc || s_ir !== ir_of(next_pc))
               $display("FAIL rnd_order c=%0d: pc=%h ir=%h required %h %h", c, s_pc, s_ir, next_pc, ir_of(next_pc));
            else n_pass++;
            next_pc = next_pc + 32'd4;
            delivered++;
         end
         if (redirect_valid) next_pc = {redirect_target[31:2], 2'b00};
         prev_hold     = s_valid && !s_ready && !redirect_valid;
         held_pc       = s_pc;
         held_ir       = s_ir;
         prev_redirect = redirect_valid;
         advance();
      end
      bubble = 1'b0; redirect_valid = 1'b0; decode_if.tready = 1'b1;
      n_total++; if (delivered < 300) $display("FAIL rnd_progress: delivered %0d required >= 300", delivered); else n_pass++;
   endtask

   initial begin
      seed = $urandom();
      test_reset();
      test_bubble();
      test_backpressure();
      test_redirect();
      test_redirect_bubble();
      test_wrap();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0000_0000, the first PC fetched after reset.
REQ-002 SHALL have port clk  input  1  single clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bubble  input  1  hazard stall request; no new fetch is issued while high.
REQ-005 SHALL have port redirect_valid  input  1  jump or taken branch resolved in execute.
REQ-006 SHALL have port redirect_target  input  32  new PC accompanying redirect_valid.
REQ-007 SHALL have port imem_en  output  1  instruction memory read strobe.
REQ-008 SHALL have port imem_addr  output  32  instruction memory byte address, word aligned.
REQ-009 SHALL have port imem_data  input  32  read data, valid exactly one cycle after imem_en.
REQ-010 SHALL have port decode  axis.master  64  TDATA = {pc[31:0], ir[31:0]}, with TVALID and TREADY handshake.

Function
REQ-011 SHALL hold PC in a register, reset to RESET_ADDR, and drive imem_addr = PC.
REQ-012 SHALL assert imem_en when bubble=0, no redirect is pending, and the output path has a free slot.
REQ-013 SHALL increment PC by 4 on each issued fetch, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-014 SHALL present a fetched instruction on decode one cycle after issue, tagged with the PC it was fetched from.
REQ-015 SHALL keep decode.tdata stable while decode.tvalid=1 and decode.tready=0.
REQ-016 SHALL capture imem_data that returns during backpressure in a one-entry skid register, so no instruction is lost or duplicated.
REQ-017 SHALL sustain one instruction per cycle when bubble=0 and decode.tready=1.
REQ-018 SHALL run a three-state FSM:
- RUN: issue fetches.
- STALL: bubble=1 or no free slot; issue nothing.
- FLUSH: one cycle after a redirect; imem_data is discarded.
REQ-019 SHALL move RUN->STALL when bubble=1 or slots are full, and STALL->RUN when both conditions clear.
REQ-020 SHALL move any state->FLUSH on redirect_valid, and FLUSH->RUN (or STALL if bubble=1) after one cycle.
REQ-021 SHALL give redirect priority over bubble and backpressure: load PC <= {redirect_target[31:2],2'b00} and invalidate the output and skid entries in the same edge.
REQ-022 SHALL, on simultaneous redirect_valid and bubble, load the target PC but issue no fetch until bubble clears.
REQ-023 SHALL, on simultaneous redirect_valid and a decode handshake, complete the handshake and then flush.
REQ-024 SHALL not assert decode.tvalid while in FLUSH.

Reset
REQ-025 SHALL on reset set PC=RESET_ADDR, FSM=RUN, imem_en=0, decode.tvalid=0, and the skid entry invalid.
REQ-026 SHALL, when reset is asserted mid-operation, drop all in-flight and held instructions immediately and asynchronously.
REQ-027 SHALL issue the first fetch of RESET_ADDR in the first cycle after reset deasserts, if bubble=0.

Structure
REQ-028 SHALL take typedef fetch_t {pc, ir} and constant RESET_ADDR default from package core.
REQ-029 SHALL implement the backpressure buffer as a sub-module named skid.
REQ-030 SHALL keep the FSM state enum local to fetch.

Verification
REQ-031 SHALL cover reset release with bubble=0 and tready=1 -> tdata pc = 0x0, 0x4, 0x8 on consecutive cycles, with tvalid continuously high.
REQ-032 SHALL cover bubble held high 3 cycles at PC=0x10 -> no imem_en during those cycles, and 0x10 resumes the cycle after bubble drops, with no gap or duplicate.
REQ-033 SHALL cover redirect_valid with target 0x200 while 0x20 is in flight -> 0x20 is never delivered, and the next delivered pc is 0x200.
REQ-034 SHALL cover tready low 4 cycles mid-stream -> tdata is held constant, no instruction is lost, and the sequence continues in order.
REQ-035 SHALL cover redirect to 0x103 together with bubble=1 -> first fetch is at 0x100, issued only after bubble drops.
REQ-036 SHALL cover PC=0xFFFF_FFFC -> the next pc is 0x0000_0000.
